bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
// - Shares one 32-bit memory bus between the IF stage (instruction fetch) and the MEM stage (load/store).
// - Sits between the pipeline and the unified memory, in place of the separate instruction ROM port.
// - Generates the pipeline stall vector while any access is outstanding.
// PARAMETERS
// - ADDR_W   32  address width, all ports
// - DATA_W   32  data width, all ports
// - TIMEOUT  16  watchdog limit in cycles waiting for bus_ack; only used with ARB_TIMEOUT_EN
// PORTS
// - clk        in   1       clock; all state on rising edge
// - rst        in   1       asynchronous, active-low reset
// - if_req     in   1       IF read request (level)
// - if_addr    in   ADDR_W  IF fetch address
// - if_rdata   out  DATA_W  fetched instruction; valid while if_ack=1
// - if_ack     out  1       one-cycle completion pulse to IF
// - mem_req    in   1       MEM request (level)
// - mem_we     in   1       1 = store, 0 = load
// - mem_sel    in   4       byte lane enables
// - mem_addr   in   ADDR_W  data address
// - mem_wdata  in   DATA_W  store data
// - mem_rdata  out  DATA_W  load data; valid while mem_ack=1
// - mem_ack    out  1       one-cycle completion pulse to MEM
// - bus_cyc    out  1       bus cycle active
// - bus_we     out  1       bus write enable
// - bus_sel    out  4       bus byte lanes
// - bus_addr   out  ADDR_W  bus address
// - bus_wdata  out  DATA_W  bus write data
// - bus_rdata  in   DATA_W  bus read data; valid with bus_ack
// - bus_ack    in   1       slave completion; sampled only while bus_cyc=1
// - stall_o    out  6       {wb,mem,ex,id,if,pc} stall requests to pipeline control
// - bus_err    out  1       sticky timeout flag; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
// - FSM states: IDLE, IF_BUS, MEM_BUS, RESP. Reset: IDLE; every registered output is 0.
// - IDLE: a port is pending when req=1 and its ack=0.
//   - MEM pending: go to MEM_BUS.
//   - else IF pending: go to IF_BUS.
//   - MEM has priority (older instruction).
//   - Fairness: if IF was pending when a MEM grant was taken, the next IDLE grant goes to IF.
// - Grant edge: register bus_addr/we/sel/wdata from the winner and set bus_cyc=1.
//   - For IF: bus_we=0, bus_sel=4'hF.
//   - Bus outputs stay stable until the ack edge.
// - IF_BUS/MEM_BUS: stay while bus_ack=0.
//   - On bus_ack=1: bus_cyc<=0, capture bus_rdata into the owner's rdata, raise the owner's ack, go to RESP.
// - RESP: ack high for exactly 1 cycle, then cleared. Return to IDLE; no grant is made in RESP.
//   - Minimum request-to-ack latency is 3 cycles with a zero-wait slave.
// - Requesters must drop or advance req in the cycle their ack is high. req is ignored while its own ack=1.
// - if_rdata/mem_rdata hold their last value after ack. Store acks return mem_rdata unchanged.
// - stall_o is combinational:
//   - MEM pending or owning the bus: 6'b011111.
//   - Otherwise, IF pending or owning the bus: 6'b000111.
//   - Otherwise: 6'b000000.
// - Simultaneous if_req and mem_req in IDLE: MEM wins; IF is served immediately after (fairness bit).
// - req deasserted while its transaction is on the bus: the transaction completes; the ack is still pulsed.
// - bus_ack outside IF_BUS/MEM_BUS is ignored.
// - Reset asserted mid-transaction: immediate IDLE; bus_cyc=0, acks=0, stall_o reflects only live req inputs.
//   - The abandoned transaction is not re-issued.
// CONFIGURATION
// - ARB_TIMEOUT_EN defined:
//   - 5-bit wait counter clears at each grant and increments each bus-wait cycle.
//   - On reaching TIMEOUT with no bus_ack: force completion with rdata=0, pulse the owner's ack, set bus_err.
//   - bus_err clears only on reset.
// - ARB_TIMEOUT_EN undefined: no counter; wait indefinitely for bus_ack; bus_err tied 0.
// TESTING
// - IF-only: if_req=1, if_addr=32'h0000_0010, slave acks 1st bus cycle with 32'h3401_1100
//   -> bus_cyc 1 cycle, if_ack pulse on cycle 3, if_rdata=32'h3401_1100, stall_o=6'b000111 until ack.
// - Collision: if_req and mem_req (load 32'h0000_0100) raised the same cycle
//   -> MEM granted first, stall_o=6'b011111; IF granted in the IDLE after RESP.
// - Store: mem_we=1, mem_sel=4'b0011, mem_wdata=32'hDEAD_BEEF, 3 wait states
//   -> bus_we/sel/wdata stable for 4 cycles, one mem_ack pulse, mem_rdata unchanged.
// - Back-to-back MEM with IF pending: second mem_req waits; IF served between the two MEM accesses.
// - Reset mid-op: drop rst during MEM_BUS wait
//   -> bus_cyc=0, mem_ack=0 immediately; after release, no spurious ack for the old request.
// - ARB_TIMEOUT_EN, TIMEOUT=16: slave never acks
//   -> 16 wait cycles, then mem_ack pulse with mem_rdata=0, bus_err=1 held until reset.

Source files
------------

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Shares one 32-bit memory bus between the IF stage (instruction
//            fetch) and the MEM stage (load/store). MEM has priority, with a
//            fairness bit so a starved IF is served right after a MEM access.
//            Produces the pipeline stall vector while any access is
//            outstanding.
// Options  : ARB_TIMEOUT_EN - enables the bus_ack watchdog and sticky bus_err
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active-low

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,

    output logic              bus_cyc,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,

    output logic [5:0]        stall_o,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IF_BUS  = 2'd1,
        S_MEM_BUS = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [5:0] C_STALL_MEM  = 6'b011111;
    localparam logic [5:0] C_STALL_IF   = 6'b000111;
    localparam logic [5:0] C_STALL_NONE = 6'b000000;

    state_t              state_q,     state_d;
    logic                fair_q,      fair_d;
    logic                bus_cyc_q,   bus_cyc_d;
    logic                bus_we_q,    bus_we_d;
    logic [3:0]          bus_sel_q,   bus_sel_d;
    logic [ADDR_W-1:0]   bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                if_ack_q,    if_ack_d;
    logic                mem_ack_q,   mem_ack_d;

    logic                w_if_pend;
    logic                w_mem_pend;
    logic                w_on_bus;
    logic                w_tmo;       // watchdog forces completion this cycle

    // A request is ignored during the cycle its own ack is being returned.
    assign w_if_pend  = if_req  & ~if_ack_q;
    assign w_mem_pend = mem_req & ~mem_ack_q;
    assign w_on_bus   = (state_q == S_IF_BUS) || (state_q == S_MEM_BUS);

`ifdef ARB_TIMEOUT_EN
    localparam logic [4:0] C_TMO_LAST = 5'(TIMEOUT - 1);

    logic [4:0] wait_cnt_q, wait_cnt_d;
    logic       bus_err_q,  bus_err_d;

    // Watchdog fires on the last allowed wait cycle when the slave stays silent.
    assign w_tmo = w_on_bus && !bus_ack && (wait_cnt_q == C_TMO_LAST);

    // Wait counter is held at zero outside a bus cycle so every grant starts fresh.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        bus_err_d  = bus_err_q;
        if (!w_on_bus) begin
            wait_cnt_d = 5'd0;
        end else if (!bus_ack) begin
            wait_cnt_d = wait_cnt_q + 5'd1;
        end
        if (w_tmo) begin
            bus_err_d = 1'b1;
        end
    end

    // Watchdog state; bus_err is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= 5'd0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic w_unused_tmo;

    // Without the watchdog the arbiter waits on bus_ack indefinitely.
    assign w_tmo        = 1'b0;
    assign bus_err      = 1'b0;
    assign w_unused_tmo = ^TIMEOUT;
`endif

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        fair_d      = fair_q;
        bus_cyc_d   = bus_cyc_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // IF wins when MEM is idle, or when IF was passed over last time.
                if (w_if_pend && (fair_q || !w_mem_pend)) begin
                    state_d    = S_IF_BUS;
                    fair_d     = 1'b0;
                    bus_cyc_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = 4'hF;
                    bus_addr_d = if_addr;
                end else if (w_mem_pend) begin
                    state_d     = S_MEM_BUS;
                    fair_d      = w_if_pend;
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_sel_d   = mem_sel;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                end
            end

            S_IF_BUS: begin
                if (bus_ack || w_tmo) begin
                    state_d    = S_RESP;
                    bus_cyc_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = w_tmo ? '0 : bus_rdata;
                end
            end

            S_MEM_BUS: begin
                if (bus_ack || w_tmo) begin
                    state_d   = S_RESP;
                    bus_cyc_d = 1'b0;
                    mem_ack_d = 1'b1;
                    // Stores leave the load-data register untouched.
                    if (!bus_we_q) begin
                        mem_rdata_d = w_tmo ? '0 : bus_rdata;
                    end
                end
            end

            S_RESP: begin
                // Ack is visible for this one cycle; no grant is made here.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; reset abandons any bus cycle in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            fair_q      <= 1'b0;
            bus_cyc_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'h0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fair_q      <= fair_d;
            bus_cyc_q   <= bus_cyc_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
        end
    end

    // Stall vector: MEM activity freezes everything up to MEM, IF only the front end.
    always_comb begin
        stall_o = C_STALL_NONE;
        if (w_mem_pend || (state_q == S_MEM_BUS)) begin
            stall_o = C_STALL_MEM;
        end else if (w_if_pend || (state_q == S_IF_BUS)) begin
            stall_o = C_STALL_IF;
        end
    end

    assign bus_cyc   = bus_cyc_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed self-checking bench for bus_arbiter with a simple
//            configurable-wait bus slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_cyc;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'h0;
    logic        bus_ack;
    logic [5:0]  stall_o;
    logic        bus_err;

    int          checks = 0;
    int          errors = 0;

    int          slave_wait  = 0;
    logic        slave_never = 1'b0;
    logic [31:0] slave_rdata = 32'h0;
    logic        slave_ack   = 1'b0;
    logic        stray_ack   = 1'b0;
    int          wcnt        = 0;

    assign bus_ack = slave_ack | stray_ack;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_cyc   (bus_cyc),
        .bus_we    (bus_we),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .stall_o   (stall_o),
        .bus_err   (bus_err)
    );

    // Slave: acks after slave_wait idle cycles of an active bus cycle.
    always @(negedge clk) begin
        if (bus_cyc && !slave_never) begin
            if (wcnt == slave_wait) begin
                slave_ack = 1'b1;
                bus_rdata = slave_rdata;
                wcnt      = 0;
            end else begin
                slave_ack = 1'b0;
                wcnt      = wcnt + 1;
            end
        end else begin
            slave_ack = 1'b0;
            wcnt      = 0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++; if ({bus_cyc, bus_we, bus_sel} !== 6'b0) begin errors++; $display("FAIL reset_bus_ctl: got %b want 000000", {bus_cyc, bus_we, bus_sel}); end
        checks++; if ({if_ack, mem_ack, bus_err} !== 3'b0) begin errors++; $display("FAIL reset_acks: got %b want 000", {if_ack, mem_ack, bus_err}); end
        checks++; if ((bus_addr | bus_wdata | if_rdata | mem_rdata) !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus_addr | bus_wdata | if_rdata | mem_rdata); end
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL reset_stall: got %b want 000000", stall_o); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_if_only;
        slave_rdata = 32'h3401_1100;
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        #1;
        checks++; if (stall_o !== 6'b000111) begin errors++; $display("FAIL if_stall_req: got %b want 000111", stall_o); end
        tick();
        checks++; if ({bus_cyc, bus_we, bus_sel} !== 6'b101111) begin errors++; $display("FAIL if_grant_ctl: got %b want 101111", {bus_cyc, bus_we, bus_sel}); end
        checks++; if (bus_addr !== 32'h0000_0010) begin errors++; $display("FAIL if_grant_addr: got %h want 00000010", bus_addr); end
        checks++; if (if_ack !== 1'b0 || stall_o !== 6'b000111) begin errors++; $display("FAIL if_wait: ack %b stall %b want 0 000111", if_ack, stall_o); end
        tick();
        checks++; if (if_ack !== 1'b1 || bus_cyc !== 1'b0) begin errors++; $display("FAIL if_ack_pulse: ack %b cyc %b want 1 0", if_ack, bus_cyc); end
        checks++; if (if_rdata !== 32'h3401_1100) begin errors++; $display("FAIL if_rdata: got %h want 34011100", if_rdata); end
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL if_stall_ack: got %b want 000000", stall_o); end
        if_req = 1'b0;
        tick();
        checks++; if (if_ack !== 1'b0 || if_rdata !== 32'h3401_1100) begin errors++; $display("FAIL if_after: ack %b rdata %h want 0 34011100", if_ack, if_rdata); end
    endtask

    task automatic test_collision;
        slave_rdata = 32'hCAFE_0001;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0020;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_sel  = 4'hF;
        mem_addr = 32'h0000_0100;
        #1;
        checks++; if (stall_o !== 6'b011111) begin errors++; $display("FAIL col_stall: got %b want 011111", stall_o); end
        tick();
        checks++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h0000_0100 || bus_we !== 1'b0) begin errors++; $display("FAIL col_mem_first: cyc %b addr %h we %b want 1 00000100 0", bus_cyc, bus_addr, bus_we); end
        tick();
        checks++; if (mem_ack !== 1'b1 || mem_rdata !== 32'hCAFE_0001 || if_ack !== 1'b0) begin errors++; $display("FAIL col_mem_ack: ack %b rdata %h ifack %b want 1 cafe0001 0", mem_ack, mem_rdata, if_ack); end
        checks++; if (stall_o !== 6'b000111) begin errors++; $display("FAIL col_stall_resp: got %b want 000111", stall_o); end
        mem_req = 1'b0;
        slave_rdata = 32'h0BAD_F00D;
        tick();
        checks++; if (bus_cyc !== 1'b0 || mem_ack !== 1'b0) begin errors++; $display("FAIL col_resp_nogrant: cyc %b ack %b want 0 0", bus_cyc, mem_ack); end
        tick();
        checks++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h0000_0020 || bus_sel !== 4'hF) begin errors++; $display("FAIL col_if_grant: cyc %b addr %h sel %h want 1 00000020 f", bus_cyc, bus_addr, bus_sel); end
        tick();
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h0BAD_F00D || mem_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL col_if_ack: ack %b rdata %h memrdata %h want 1 0badf00d cafe0001", if_ack, if_rdata, mem_rdata); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        slave_rdata = 32'h1111_1111;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0400;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0040;
        tick();
        checks++; if (bus_addr !== 32'h0000_0400) begin errors++; $display("FAIL b2b_first_mem: got %h want 00000400", bus_addr); end
        tick();
        checks++; if (mem_ack !== 1'b1 || mem_rdata !== 32'h1111_1111) begin errors++; $display("FAIL b2b_ack1: ack %b rdata %h want 1 11111111", mem_ack, mem_rdata); end
        mem_addr    = 32'h0000_0404;
        slave_rdata = 32'h2222_2222;
        tick();
        checks++; if (bus_cyc !== 1'b0 || stall_o !== 6'b011111) begin errors++; $display("FAIL b2b_idle: cyc %b stall %b want 0 011111", bus_cyc, stall_o); end
        tick();
        checks++; if (bus_addr !== 32'h0000_0040 || bus_we !== 1'b0) begin errors++; $display("FAIL b2b_if_between: addr %h we %b want 00000040 0", bus_addr, bus_we); end
        tick();
        checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h2222_2222) begin errors++; $display("FAIL b2b_if_ack: ack %b rdata %h want 1 22222222", if_ack, if_rdata); end
        if_req      = 1'b0;
        slave_rdata = 32'h3333_3333;
        tick();
        tick();
        checks++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h0000_0404) begin errors++; $display("FAIL b2b_second_mem: cyc %b addr %h want 1 00000404", bus_cyc, bus_addr); end
        tick();
        checks++; if (mem_ack !== 1'b1 || mem_rdata !== 32'h3333_3333) begin errors++; $display("FAIL b2b_ack2: ack %b rdata %h want 1 33333333", mem_ack, mem_rdata); end
        mem_req = 1'b0;
        tick();
    endtask

    task automatic test_store;
        slave_wait  = 3;
        slave_rdata = 32'h5555_AAAA;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_sel   = 4'b0011;
        mem_addr  = 32'h0000_0200;
        mem_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_wdata = 32'h0;
            checks++;
            if ({bus_cyc, bus_we, bus_sel} !== 6'b110011 || bus_wdata !== 32'hDEAD_BEEF || bus_addr !== 32'h0000_0200 || mem_ack !== 1'b0) begin
                errors++;
                $display("FAIL store_stable[%0d]: cyc/we/sel %b wdata %h addr %h ack %b want 110011 deadbeef 00000200 0", i, {bus_cyc, bus_we, bus_sel}, bus_wdata, bus_addr, mem_ack);
            end
        end
        tick();
        checks++; if (mem_ack !== 1'b1 || bus_cyc !== 1'b0) begin errors++; $display("FAIL store_ack: ack %b cyc %b want 1 0", mem_ack, bus_cyc); end
        checks++; if (mem_rdata !== 32'h3333_3333) begin errors++; $display("FAIL store_rdata_hold: got %h want 33333333", mem_rdata); end
        mem_req = 1'b0;
        mem_we  = 1'b0;
        tick();
        checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL store_single_pulse: got %b want 0", mem_ack); end
        slave_wait = 0;
        tick();
    endtask

    task automatic test_stray_ack;
        stray_ack = 1'b1;
        tick();
        tick();
        checks++; if ({if_ack, mem_ack, bus_cyc} !== 3'b000 || stall_o !== 6'b0) begin errors++; $display("FAIL stray_ack: acks/cyc %b stall %b want 000 000000", {if_ack, mem_ack, bus_cyc}, stall_o); end
        stray_ack = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        int cycles;
        bit seen;
        slave_never = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0500;
        tick();
`ifdef ARB_TIMEOUT_EN
        cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (mem_ack) break;
            if (bus_cyc) cycles++;
            tick();
        end
        checks++; if (cycles != 16) begin errors++; $display("FAIL tmo_wait_cycles: got %0d want 16", cycles); end
        checks++; if (mem_ack !== 1'b1 || mem_rdata !== 32'h0 || bus_err !== 1'b1) begin errors++; $display("FAIL tmo_force: ack %b rdata %h err %b want 1 0 1", mem_ack, mem_rdata, bus_err); end
        mem_req = 1'b0;
        tick(); tick(); tick();
        checks++; if (bus_err !== 1'b1 || mem_ack !== 1'b0) begin errors++; $display("FAIL tmo_sticky: err %b ack %b want 1 0", bus_err, mem_ack); end
        rst = 1'b0;
        #1;
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b want 0", bus_err); end
        @(negedge clk);
        rst = 1'b1;
        slave_never = 1'b0;
        tick();
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (bus_cyc !== 1'b1 || mem_ack !== 1'b0 || bus_err !== 1'b0) begin
                errors++;
                $display("FAIL nowdog_wait[%0d]: cyc %b ack %b err %b want 1 0 0", k, bus_cyc, mem_ack, bus_err);
            end
        end
        slave_rdata = 32'h7777_0000;
        slave_never = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (mem_ack) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (!seen || mem_rdata !== 32'h7777_0000) begin errors++; $display("FAIL nowdog_late_ack: seen %b rdata %h want 1 77770000", seen, mem_rdata); end
        mem_req = 1'b0;
        tick();
        cycles = 0;
`endif
    endtask

    task automatic test_reset_midop;
        slave_never = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0300;
        tick();
        tick();
        checks++; if (bus_cyc !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b want 1", bus_cyc); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus_cyc !== 1'b0 || mem_ack !== 1'b0) begin errors++; $display("FAIL midop_async: cyc %b ack %b want 0 0", bus_cyc, mem_ack); end
        checks++; if (stall_o !== 6'b011111) begin errors++; $display("FAIL midop_stall_live: got %b want 011111", stall_o); end
        mem_req = 1'b0;
        #1;
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL midop_stall_drop: got %b want 000000", stall_o); end
        @(negedge clk);
        rst = 1'b1;
        slave_never = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (mem_ack !== 1'b0 || bus_cyc !== 1'b0) begin
                errors++;
                $display("FAIL midop_no_reissue[%0d]: ack %b cyc %b want 0 0", k, mem_ack, bus_cyc);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;

        test_reset();
        test_if_only();
        test_collision();
        test_back_to_back();
        test_store();
        test_stray_ack();
        test_timeout();
        test_reset_midop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
